// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream packet arbiter: NUM_PORTS masters share one downstream port.
// Optional stall watchdog enabled by defining AXIS_ARB_TIMEOUT_EN.
module axis_rr_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_PORTS-1:0]        s_tvalid,
    input  logic [NUM_PORTS*DATA_W-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]        s_tlast,
    output logic [NUM_PORTS-1:0]        s_tready,
    output logic                        m_tvalid,
    output logic [DATA_W-1:0]           m_tdata,
    output logic                        m_tlast,
    input  logic                        m_tready,
    output logic [NUM_PORTS-1:0]        grant,
    output logic                        timeout
);

    localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT < 1) begin : gen_bad_param
        $error("axis_rr_arbiter: NUM_PORTS must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e              state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic                pick_valid;
    logic [IdxW-1:0]     pick_idx;
    logic                beat;
    logic                done;
    logic                expire;

    // First requester at or after last_winner+1, wrapping.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            idx = (32'(last_q) + k) % NUM_PORTS;
            if (!pick_valid && s_tvalid[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = IdxW'(idx);
            end
        end
    end

    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        s_tready = '0;
        if (state_q == StXfer) begin
            m_tvalid = s_tvalid[owner_q];
            m_tdata  = s_tdata[32'(owner_q) * DATA_W +: DATA_W];
            m_tlast  = s_tlast[owner_q];
            s_tready = grant_q & {NUM_PORTS{m_tready}};
        end
    end

    assign beat = m_tvalid && m_tready;

`ifdef AXIS_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] stall_q, stall_d;
    logic            timeout_q;

    assign expire = (state_q == StXfer) && !beat && (stall_q == CntW'(TIMEOUT - 1));

    always_comb begin
        stall_d = '0;
        if (state_q == StXfer && !beat && !expire) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= expire;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = NUM_PORTS'(1) << pick_idx;
                    owner_d = pick_idx;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                done = (beat && m_tlast) || expire;
                if (done) begin
                    grant_d = '0;
                    last_d  = owner_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IdxW'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (4 ports, 8-bit data).
// Port p sends bytes {p, beat_index}; tlast on the last beat of each src_len-beat packet.
module tb_axis_rr_arbiter;

    logic        clk;
    logic        resetn;
    logic [3:0]  s_tvalid;
    logic [31:0] s_tdata;
    logic [3:0]  s_tlast;
    logic [3:0]  s_tready;
    logic        m_tvalid;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic [3:0]  grant;
    logic        timeout;

    int checks;
    int failures;

    logic [3:0] src_en;
    int         src_beat [4];
    int         src_len;

    axis_rr_arbiter #(
        .NUM_PORTS(4),
        .DATA_W   (8),
        .TIMEOUT  (16)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .s_tvalid(s_tvalid),
        .s_tdata (s_tdata),
        .s_tlast (s_tlast),
        .s_tready(s_tready),
        .m_tvalid(m_tvalid),
        .m_tdata (m_tdata),
        .m_tlast (m_tlast),
        .m_tready(m_tready),
        .grant   (grant),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive();
        for (int p = 0; p < 4; p++) begin
            s_tvalid[p]         = src_en[p];
            s_tdata[p*8 +: 8]   = {p[3:0], src_beat[p][3:0]};
            s_tlast[p]          = (src_beat[p] % src_len) == (src_len - 1);
        end
    endtask

    // Advance one clock; sources that handshook on this edge move to their next beat.
    task automatic step();
        logic [3:0] hs;
        #1;
        hs = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) if (hs[p]) src_beat[p]++;
        drive();
        #1;
    endtask

    task automatic apply_reset();
        resetn   = 1'b0;
        src_en   = 4'b0000;
        src_len  = 2;
        m_tready = 1'b1;
        for (int p = 0; p < 4; p++) src_beat[p] = 0;
        drive();
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        src_len  = 2;
        m_tready = 1'b1;
        src_en   = 4'b1111;
        for (int p = 0; p < 4; p++) src_beat[p] = 0;
        drive();
        repeat (3) @(posedge clk);
        #2;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%b exp=0", m_tvalid); end
        checks++; if (s_tready !== 4'b0000) begin failures++; $display("FAIL reset_s_tready got=%b exp=0000", s_tready); end
        checks++; if (m_tdata !== 8'h00) begin failures++; $display("FAIL reset_m_tdata got=%h exp=00", m_tdata); end
        checks++; if (m_tlast !== 1'b0) begin failures++; $display("FAIL reset_m_tlast got=%b exp=0", m_tlast); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        resetn = 1'b1;
        step();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL reset_first_prio got=%b exp=0001", grant); end
    endtask

    task automatic test_single_packet();
        logic [7:0] exp_d [3] = '{8'h20, 8'h21, 8'h22};
        apply_reset();
        src_len = 3;
        src_en  = 4'b0100;
        drive();
        #1;
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL single_idle_valid got=%b exp=0", m_tvalid); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL single_grant[%0d] got=%b exp=0100", i, grant); end
            checks++; if (m_tdata !== exp_d[i]) begin failures++; $display("FAIL single_data[%0d] got=%h exp=%h", i, m_tdata, exp_d[i]); end
            checks++; if (m_tlast !== (i == 2)) begin failures++; $display("FAIL single_last[%0d] got=%b exp=%b", i, m_tlast, i == 2); end
            checks++; if (s_tready !== 4'b0100) begin failures++; $display("FAIL single_ready[%0d] got=%b exp=0100", i, s_tready); end
        end
        src_en = 4'b0000;
        step();
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL single_release got=%b exp=0000", grant); end
        checks++; if (src_beat[2] !== 3) begin failures++; $display("FAIL single_beats got=%0d exp=3", src_beat[2]); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [14] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4,
                                   4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
        logic [7:0] exp_d [14] = '{8'h00, 8'h01, 8'h00, 8'h10, 8'h11, 8'h00, 8'h20,
                                   8'h21, 8'h00, 8'h30, 8'h31, 8'h00, 8'h02, 8'h03};
        apply_reset();
        src_en = 4'b1111;
        drive();
        for (int k = 0; k < 14; k++) begin
            step();
            checks++; if (grant !== exp_g[k]) begin failures++; $display("FAIL rot_grant[%0d] got=%b exp=%b", k, grant, exp_g[k]); end
            if (exp_g[k] != 4'h0) begin
                checks++; if (m_tdata !== exp_d[k]) begin failures++; $display("FAIL rot_data[%0d] got=%h exp=%h", k, m_tdata, exp_d[k]); end
                checks++; if (m_tlast !== exp_d[k][0]) begin failures++; $display("FAIL rot_last[%0d] got=%b exp=%b", k, m_tlast, exp_d[k][0]); end
            end else begin
                checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rot_idle_valid[%0d] got=%b exp=0", k, m_tvalid); end
            end
        end
    endtask

    task automatic test_hold_backpressure();
        logic       mr    [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] exp_g [7] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h1};
        logic [7:0] exp_d [7] = '{8'h10, 8'h11, 8'h11, 8'h12, 8'h12, 8'h00, 8'h00};
        logic       exp_l [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] exp_r [7] = '{4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h0, 4'h1};
        apply_reset();
        src_len = 3;
        src_en  = 4'b0010;
        drive();
        step();
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL hold_grant_start got=%b exp=0010", grant); end
        src_en = 4'b0011;
        drive();
        for (int i = 0; i < 7; i++) begin
            m_tready = mr[i];
            step();
            checks++; if (grant !== exp_g[i]) begin failures++; $display("FAIL hold_grant[%0d] got=%b exp=%b", i, grant, exp_g[i]); end
            checks++; if (s_tready !== exp_r[i]) begin failures++; $display("FAIL hold_ready[%0d] got=%b exp=%b", i, s_tready, exp_r[i]); end
            if (exp_g[i] != 4'h0) begin
                checks++; if (m_tdata !== exp_d[i]) begin failures++; $display("FAIL hold_data[%0d] got=%h exp=%h", i, m_tdata, exp_d[i]); end
                checks++; if (m_tlast !== exp_l[i]) begin failures++; $display("FAIL hold_last[%0d] got=%b exp=%b", i, m_tlast, exp_l[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        src_len = 4;
        src_en  = 4'b0100;
        drive();
        step();
        step();
        checks++; if (m_tdata !== 8'h21) begin failures++; $display("FAIL midrst_beat2 got=%h exp=21", m_tdata); end
        resetn = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL midrst_grant got=%b exp=0000", grant); end
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", m_tvalid); end
        checks++; if (s_tready !== 4'b0000) begin failures++; $display("FAIL midrst_ready got=%b exp=0000", s_tready); end
        checks++; if (m_tdata !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", m_tdata); end
        @(posedge clk);
        #3;
        resetn = 1'b1;
        src_en = 4'b0101;
        drive();
        step();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL midrst_prio got=%b exp=0001", grant); end
        checks++; if (m_tdata !== 8'h00) begin failures++; $display("FAIL midrst_prio_data got=%h exp=00", m_tdata); end
    endtask

    task automatic test_timeout();
        apply_reset();
        src_len = 4;
        src_en  = 4'b1000;
        drive();
        step();
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL to_grant got=%b exp=1000", grant); end
        src_en = 4'b0000;
        drive();
`ifdef AXIS_ARB_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            step();
            checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL to_hold[%0d] got=%b exp=1000", k, grant); end
            checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_early[%0d] got=%b exp=0", k, timeout); end
        end
        step();
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL to_release got=%b exp=0000", grant); end
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b exp=1", timeout); end
        src_en = 4'b0001;
        drive();
        step();
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_pulse_end got=%b exp=0", timeout); end
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL to_next got=%b exp=0001", grant); end
`else
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL nto_hold[%0d] got=%b exp=1000", k, grant); end
            checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL nto_pulse[%0d] got=%b exp=0", k, timeout); end
        end
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL nto_valid got=%b exp=0", m_tvalid); end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        m_tready = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        src_en   = '0;
        src_len  = 2;
        for (int p = 0; p < 4; p++) src_beat[p] = 0;
        test_reset();
        test_single_packet();
        test_rotation();
        test_hold_backpressure();
        test_reset_mid_packet();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
